// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU sequencer.
// State encoding, opcodes and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 2;
  localparam int IMM_HI = 1;
  localparam int IMM_LO = 0;

  function automatic logic [1:0] op_of(input logic [7:0] i);
    return i[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait counter for memory handshakes.
// expired is high in the last allowed waiting cycle.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 8'd1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer.
// Owns pc and ir; strobes register-file and memory controls.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic [1:0] sext_in,
  input  logic [7:0] sext_val,
  output logic [7:0] ir,
  output logic [7:0] pc,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       busy,
  output logic       retired,
  output logic       fault
);

  state_t     state, nxt;
  logic [1:0] op;
  logic       wait_en;
  logic       tmo;
  state_t     after;

  assign op    = op_of(ir);
  assign after = run ? FETCH : IDLE;

  // Timer runs only while a request is outstanding; any ack resets it
  assign wait_en = (imem_req && !imem_ack) ||
                   (dmem_req && !dmem_ack);

  ack_timer #(.LIMIT(MEM_TIMEOUT)) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!wait_en),
    .en      (wait_en),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (run) nxt = FETCH;
      FETCH:  if (imem_ack) nxt = DECODE;
              else if (tmo) nxt = FAULT;
      DECODE: nxt = EXEC;
      EXEC: begin
        unique case (1'b1)
          op == OP_JMP: nxt = after;
          op == OP_ADD: nxt = WB;
          default:      nxt = MEM;
        endcase
      end
      MEM: begin
        if (dmem_ack) nxt = (op == OP_LW) ? WB : after;
        else if (tmo) nxt = FAULT;
      end
      WB:     nxt = after;
      FAULT:  nxt = FAULT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH);
    dmem_req   = (state == MEM);
    dmem_we    = (state == MEM) && (op == OP_SW);
    reg_write  = (state == WB);
    mem_to_reg = (state == WB) && (op == OP_LW);
    busy       = (state != IDLE) && (state != FAULT);
    fault      = (state == FAULT);
    retired    = (state == WB) ||
                 ((state == EXEC) && (op == OP_JMP)) ||
                 ((state == MEM) && dmem_ack && (op == OP_SW));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == FETCH && imem_ack) begin
      pc <= pc + 8'd1;
      ir <= imem_data;
    end else if (state == EXEC && op == OP_JMP) begin
      pc <= pc + sext_val;
    end
  end

  assign imem_addr = pc;
  assign sext_in   = ir[IMM_HI:IMM_LO];

endmodule
